frame_det_ctrl: RTL and testbench
=================================

# frame_det_ctrl

Frame-level controller for the Moore non-overlapping "1011" serial sequence detector. It accepts a parallel frame over a valid/ready handshake and serialises it MSB-first into an embedded 1011 detector. It counts detections over the whole frame and returns the count over a second valid/ready handshake. It sits between a parallel producer and a status consumer, so the bit-serial detector never needs per-bit handshaking.

## Interface
- W, default 16: frame width in bits (W ≥ 4).
- CW, default 4: detection-count width.
- clk  in  1  rising-edge clock.
- res  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a frame.
- in_ready  out  1  controller can accept a frame; equals (state == IDLE).
- in_data  in  W  frame; bit W-1 is serialised first.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_count  out  CW  detections in the frame, saturating.
- out_hit  out  1  out_count != 0.
- busy  out  1  state is SHIFT, DRAIN or REPORT.

## Operation
- Controller FSM states and transitions:
  - IDLE → SHIFT on in_valid && in_ready.
  - SHIFT → DRAIN after W shift cycles.
  - DRAIN → REPORT after 1 cycle.
  - REPORT → IDLE on out_valid && out_ready.
- On accept:
  - shift register ← in_data; bit counter ← 0; count ← 0.
  - Detector state forced to s0, so frames are independent.
- Detector: internal Moore FSM with states s0–s4; y = (det_state == s4). Transitions on bit b:
  - s0: 1 → s1, 0 → s0.
  - s1: 1 → s1, 0 → s2.
  - s2: 1 → s3, 0 → s0.
  - s3: 1 → s4, 0 → s2.
  - s4: any → s0. The bit consumed in s4 is discarded, which makes detection non-overlapping.
- SHIFT, each cycle:
  - Present shreg[W-1] to the detector.
  - At the edge: detector advances, shreg shifts left with zero fill, bit counter increments.
  - Exit to DRAIN after the edge where bit counter == W-1.
- Counting: at every edge in SHIFT or DRAIN, if det_state == s4 then count ← min(count+1, 2^CW−1).
- DRAIN: detector does not advance. This cycle captures a detection completed by the last frame bit.
- REPORT:
  - out_valid = 1; out_count and out_hit are held stable until the handshake.
  - in_data and in_valid are ignored in SHIFT, DRAIN and REPORT (in_ready = 0).
- Reset value, all registers: state IDLE, det_state s0, count 0, shreg 0, bit counter 0.
- Output values during and after reset: in_ready = 1, out_valid = 0, out_count = 0, out_hit = 0, busy = 0.
- Reset asserted mid-frame aborts the frame; no result is produced for it.

## Timing
- Accept edge E0:
  - Bits are presented in cycles E0..E(W−1).
  - DRAIN occupies E(W)..E(W+1).
  - out_valid rises after E(W+1), i.e. W+1 clocks after accept.
- A result handshake at edge Ek gives in_ready = 1 after Ek; the next accept is possible at E(k+1).
- Minimum frame period: W+3 clocks (W+1 processing, ≥1 REPORT, 1 IDLE).
- out_ready held low stalls the block in REPORT indefinitely, with outputs stable.
- out_valid and in_ready are never both 1.
- A detection reached on the last frame bit is counted in DRAIN, not lost.

## Test plan
- Reset: res low with random inputs → in_ready = 1, out_valid = 0, out_count = 0, busy = 0. Release, apply in_data = 16'hB5AC (1011_0_1011_0_1011_00) → out_count = 3, out_hit = 1, out_valid exactly 17 clocks after accept.
- Non-overlap: 16'hB600 (1011011…) → out_count = 1. Also 16'hBB00 (10111011…), where the 5th bit is consumed in s4 → out_count = 1.
- s3 fallback path: 16'hAC00 (101011…) → out_count = 1. Also 16'h0000 and 16'hFFFF → out_count = 0, out_hit = 0.
- Last-bit detection via DRAIN: 16'h000B → out_count = 1.
- Backpressure and handshake:
  - out_ready low for 10 cycles → out_valid and out_count stable, in_ready = 0, second in_valid ignored.
  - Raise out_ready → in_ready = 1 the following cycle; back-to-back frames of 16'hB5AC then 16'h000B → counts 3, then 1, with det_state reset between frames.
- Mid-frame reset and saturation:
  - res pulsed low at bit 8 of 16'hB5AC → no out_valid; next frame 16'hAC00 → 1.
  - With CW = 1, 16'hB5AC → out_count = 1 (saturated).

Source files
------------

// File: rtl/frame_det_ctrl.sv
// rtl/frame_det_ctrl.sv - frame-level controller around a Moore non-overlapping 1011 detector
module frame_det_ctrl #(
    parameter int W  = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          res,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_hit,
    output logic          busy
);

    localparam int BCW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } ctrl_state_t;

    typedef enum logic [2:0] {
        D_S0 = 3'd0,
        D_S1 = 3'd1,
        D_S2 = 3'd2,
        D_S3 = 3'd3,
        D_S4 = 3'd4
    } det_state_t;

    ctrl_state_t    state_q, state_d;
    det_state_t     det_q, det_d, det_nx;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bit_in;

    assign bit_in = shreg_q[W-1];

    // Detector next state; the bit seen in S4 is dropped so matches never overlap.
    always_comb begin
        det_nx = D_S0;
        case (det_q)
            D_S0:    det_nx = bit_in ? D_S1 : D_S0;
            D_S1:    det_nx = bit_in ? D_S1 : D_S2;
            D_S2:    det_nx = bit_in ? D_S3 : D_S0;
            D_S3:    det_nx = bit_in ? D_S4 : D_S2;
            D_S4:    det_nx = D_S0;
            default: det_nx = D_S0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;

        // S4 is registered one edge after the fourth bit, so DRAIN catches a last-bit match.
        if ((state_q == SHIFT || state_q == DRAIN) && det_q == D_S4 && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    shreg_d = in_data;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                    det_d   = D_S0;
                end
            end
            SHIFT: begin
                det_d   = det_nx;
                shreg_d = {shreg_q[W-2:0], 1'b0};
                bcnt_d  = bcnt_q + 1'b1;
                if (bcnt_q == BIT_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = REPORT;
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            det_q   <= D_S0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == REPORT);
    assign out_count = cnt_q;
    assign out_hit   = (cnt_q != '0);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_det_ctrl.sv
// tb/tb_frame_det_ctrl.sv - randomized self-checking bench for frame_det_ctrl
module tb_frame_det_ctrl;

    localparam int W = 16;

    logic          clk;
    logic          res;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;
    logic          in_ready,  out_valid,  out_hit,  busy;
    logic [3:0]    out_count;
    logic          s_in_ready, s_out_valid, s_out_hit, s_busy;
    logic [0:0]    s_out_count;

    int n_vec;
    int n_err;

    frame_det_ctrl #(.W(W), .CW(4)) u_dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_hit(out_hit), .busy(busy)
    );

    frame_det_ctrl #(.W(W), .CW(1)) u_sat (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_count(s_out_count), .out_hit(s_out_hit), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Leftmost-match scan; a match also swallows the following bit.
    function automatic int ref_count(input logic [W-1:0] d);
        int c = 0;
        int i = 0;
        logic [3:0] win;
        while (i <= W - 4) begin
            win = {d[W-1-i], d[W-2-i], d[W-3-i], d[W-4-i]};
            if (win == 4'b1011) begin
                c++;
                i += 5;
            end else begin
                i++;
            end
        end
        return c;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [W-1:0] d, input int stall);
        int wait_cyc;
        int lat;
        int exp_c;
        logic [3:0] held;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        if (!in_ready) check_val("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        check_val("busy_after_accept", int'(busy), 1);
        check_val("in_ready_after_accept", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check_val("latency", lat, W + 1);
        exp_c = ref_count(d);
        check_val("out_count", int'(out_count), sat(exp_c, 15));
        check_val("out_hit", int'(out_hit), int'(exp_c != 0));
        check_val("sat_count", int'(s_out_count), sat(exp_c, 1));
        held = out_count;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            step();
            check_val("stall_valid", int'(out_valid), 1);
            check_val("stall_count", int'(out_count), int'(held));
            check_val("stall_exclusive", int'(in_ready && out_valid), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("post_hs_valid", int'(out_valid), 0);
        check_val("post_hs_ready", int'(in_ready), 1);
    endtask

    initial begin
        logic [W-1:0] pat;
        int seen;
        n_vec = 0;
        n_err = 0;
        res       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'($urandom);
            in_data   = W'($urandom);
            out_ready = 1'($urandom);
            step();
            check_val("rst_in_ready", int'(in_ready), 1);
            check_val("rst_out_valid", int'(out_valid), 0);
            check_val("rst_out_count", int'(out_count), 0);
            check_val("rst_busy", int'(busy), 0);
        end
        check_val("rst_out_hit", int'(out_hit), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        res = 1'b1;
        step();

        run_frame(16'hB5AC, 0);
        run_frame(16'hB600, 1);
        run_frame(16'hBB00, 0);
        run_frame(16'hAC00, 2);
        run_frame(16'h0000, 0);
        run_frame(16'hFFFF, 0);
        run_frame(16'h000B, 0);
        run_frame(16'hB5AC, 10);
        run_frame(16'hB5AC, 0);
        run_frame(16'h000B, 0);

        // Abort a frame eight bits in; no result may appear afterwards.
        in_valid = 1'b1;
        in_data  = 16'hB5AC;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        res = 1'b0;
        #1;
        check_val("abort_in_ready", int'(in_ready), 1);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_count", int'(out_count), 0);
        step();
        res = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (out_valid) seen = 1;
        end
        check_val("abort_no_result", seen, 0);
        run_frame(16'hAC00, 0);

        for (int n = 0; n < 30; n++) begin
            pat = W'($urandom);
            if ($urandom_range(0, 1) == 1) pat[W-1 -: 4] = 4'b1011;
            if ($urandom_range(0, 2) == 0) pat[3:0] = 4'b1011;
            run_frame(pat, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
